// File: rtl/shared_adder_arbiter.sv
// Round-robin arbiter sharing one W-bit adder between N_REQ requesters, with a
// single tagged result register. Define SHARED_ADD_SAT_EN to saturate the sum on carry-out.
module shared_adder_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 8,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*W-1:0]   req_a,
  input  logic [N_REQ*W-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [W-1:0]         rsp_sum,
  output logic                 rsp_carry,
  output logic [ID_W-1:0]      rsp_id
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state;
  logic [ID_W-1:0] last;
  logic [ID_W-1:0] winner;
  logic            found;
  logic [31:0]     idx;
  logic            can_take;
  logic            transfer;
  logic [W-1:0]    a_arr [N_REQ];
  logic [W-1:0]    b_arr [N_REQ];
  logic [W-1:0]    a_sel;
  logic [W-1:0]    b_sel;
  logic [W:0]      sum_full;
  logic [W-1:0]    sum_out;

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign a_arr[k] = req_a[k*W +: W];
    assign b_arr[k] = req_b[k*W +: W];
  end

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = (32'(last) + 32'(i)) % N_REQ;
      if (!found && req_valid[ID_W'(idx)]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  assign can_take = (state == EMPTY) | rsp_ready;

  always_comb begin
    req_ready = '0;
    if (can_take && found) req_ready[winner] = 1'b1;
  end

  assign transfer = |req_ready;
  assign a_sel    = a_arr[winner];
  assign b_sel    = b_arr[winner];
  assign sum_full = {1'b0, a_sel} + {1'b0, b_sel};

`ifdef SHARED_ADD_SAT_EN
  assign sum_out = sum_full[W] ? {W{1'b1}} : sum_full[W-1:0];
`else
  assign sum_out = sum_full[W-1:0];
`endif

  // Result register and EMPTY/FULL sequencing; a transfer always wins over a drain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= EMPTY;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_carry <= 1'b0;
      rsp_id    <= '0;
      last      <= ID_W'(N_REQ - 1);
    end else begin
      case (state)
        EMPTY: begin
          if (transfer) begin
            state     <= FULL;
            rsp_valid <= 1'b1;
            rsp_sum   <= sum_out;
            rsp_carry <= sum_full[W];
            rsp_id    <= winner;
            last      <= winner;
          end
        end
        FULL: begin
          if (transfer) begin
            rsp_sum   <= sum_out;
            rsp_carry <= sum_full[W];
            rsp_id    <= winner;
            last      <= winner;
          end else if (rsp_ready) begin
            state     <= EMPTY;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Directed bench for shared_adder_arbiter: a queue-free reference model checked
// every cycle, plus literal expectations from the test plan.
module tb_shared_adder_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [W-1:0]     rsp_sum;
  logic             rsp_carry;
  logic [1:0]       rsp_id;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int         m_last;
  bit         m_full;
  logic [7:0] m_sum;
  bit         m_carry;
  int         m_id;

  shared_adder_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .rsp_id(rsp_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // First valid requester found walking forward from the one after 'last'.
  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int s = 1; s <= int'(N); s++) begin
      if (v[(last + s) % N]) return (last + s) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int w;
    w = pick(req_valid, m_last);
    if ((!m_full || rsp_ready) && w >= 0) return N'(1 << w);
    return '0;
  endfunction

  function automatic logic [8:0] ref_add(input logic [7:0] a, input logic [7:0] b);
    int s;
    s = int'(a) + int'(b);
`ifdef SHARED_ADD_SAT_EN
    if (s > 255) return {1'b1, 8'hFF};
`endif
    return {(s > 255) ? 1'b1 : 1'b0, 8'(s)};
  endfunction

  // Model update on each clock edge, using the handshake rules directly.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_last = N - 1; m_full = 0; m_sum = 8'h00; m_carry = 0; m_id = 0;
    end else begin
      int w;
      logic [8:0] r;
      w = pick(req_valid, m_last);
      if ((!m_full || rsp_ready) && w >= 0) begin
        r = ref_add(req_a[w*W +: W], req_b[w*W +: W]);
        m_sum = r[7:0]; m_carry = r[8]; m_id = w; m_last = w; m_full = 1;
      end else if (rsp_ready) begin
        m_full = 0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      if (!reset_n) begin
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      end else begin
        check("mdl_req_ready", 32'(req_ready), 32'(exp_ready()));
        check("mdl_rsp_valid", 32'(rsp_valid), 32'(m_full));
        if (m_full) begin
          check("mdl_rsp_sum", 32'(rsp_sum), 32'(m_sum));
          check("mdl_rsp_carry", 32'(rsp_carry), 32'(m_carry));
          check("mdl_rsp_id", 32'(rsp_id), 32'(m_id));
        end
      end
    end
  end

  task automatic set_op(input int k, input logic [7:0] a, input logic [7:0] b);
    req_a[k*W +: W] = a;
    req_b[k*W +: W] = b;
  endtask

  // Apply inputs, check req_ready, then advance to just after the next edge.
  task automatic step(input logic [N-1:0] v, input logic rr, input logic [N-1:0] er, input string nm);
    req_valid = v;
    rsp_ready = rr;
    #1;
    check(nm, 32'(req_ready), 32'(er));
    @(posedge clk);
    #1;
  endtask

  logic [7:0] ovf1_exp, ovf2_exp;
  logic [1:0] grant_seq [8];
  logic [7:0] held_sum;
  logic [1:0] held_id;

  initial begin
`ifdef SHARED_ADD_SAT_EN
    ovf1_exp = 8'hFF; ovf2_exp = 8'hFF;
`else
    ovf1_exp = 8'h10; ovf2_exp = 8'h00;
`endif
    grant_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    reset_n = 1'b0; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0;
    #1;
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_sum", 32'(rsp_sum), 32'd0);
    check("reset_rsp_carry", 32'(rsp_carry), 32'd0);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    chk_en = 1;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;

    // Single request from requester 0
    set_op(0, 8'h12, 8'h34);
    step(4'b0001, 1'b1, 4'b0001, "single_ready");
    check("single_valid", 32'(rsp_valid), 32'd1);
    check("single_sum", 32'(rsp_sum), 32'h46);
    check("single_carry", 32'(rsp_carry), 32'd0);
    check("single_id", 32'(rsp_id), 32'd0);

    // All requesting, consumer always ready: strict rotation
    for (int k = 0; k < int'(N); k++) set_op(k, 8'(8'h50 * k), 8'h33);
    for (int i = 0; i < 8; i++) begin
      step(4'b1111, 1'b1, N'(1 << grant_seq[i]), "rr_ready");
      check("rr_id", 32'(rsp_id), 32'(grant_seq[i]));
      check("rr_valid", 32'(rsp_valid), 32'd1);
    end
    check("rr_sum_k0", 32'(rsp_sum), 32'h33);

    // Backpressure: result held, no grants
    held_sum = rsp_sum; held_id = rsp_id;
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b0, 4'b0000, "bp_ready");
      check("bp_sum", 32'(rsp_sum), 32'(held_sum));
      check("bp_id", 32'(rsp_id), 32'(held_id));
    end
    step(4'b1111, 1'b1, 4'b0010, "bp_release_ready");
    check("bp_release_id", 32'(rsp_id), 32'd1);

    // Overflow cases on requester 0
    set_op(0, 8'hF0, 8'h20);
    step(4'b0001, 1'b1, 4'b0001, "ovf1_ready");
    check("ovf1_sum", 32'(rsp_sum), 32'(ovf1_exp));
    check("ovf1_carry", 32'(rsp_carry), 32'd1);
    set_op(0, 8'hFF, 8'h01);
    step(4'b0001, 1'b1, 4'b0001, "ovf2_ready");
    check("ovf2_sum", 32'(rsp_sum), 32'(ovf2_exp));
    check("ovf2_carry", 32'(rsp_carry), 32'd1);

    // Withdrawn request: 2 drops before its turn, grant skips to 3, then 2 later
    step(4'b1110, 1'b1, 4'b0010, "wd_grant1");
    check("wd_id1", 32'(rsp_id), 32'd1);
    step(4'b1010, 1'b1, 4'b1000, "wd_skip_to3");
    check("wd_id3", 32'(rsp_id), 32'd3);
    step(4'b0100, 1'b1, 4'b0100, "wd_grant2");
    check("wd_id2", 32'(rsp_id), 32'd2);
    step(4'b0000, 1'b1, 4'b0000, "wd_drain");
    check("wd_drained", 32'(rsp_valid), 32'd0);

    // Asynchronous reset while FULL and stalled
    set_op(1, 8'h01, 8'h02);
    step(4'b0010, 1'b1, 4'b0010, "mr_fill");
    req_valid = '0; rsp_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("mr_valid_async", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    step(4'b1111, 1'b1, 4'b0001, "mr_first_ready");
    check("mr_first_id", 32'(rsp_id), 32'd0);
    step(4'b0000, 1'b1, 4'b0000, "end_drain");

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
